mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DSTREAK_MAX, default 2, giving the maximum number of consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles a grant may wait for ramstate==ACCESS.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports iREN (input, 1) and iaddr (input, word_t): the instruction-fetch read request and its address.
REQ-006 The block SHALL have ports dREN (input, 1), dWEN (input, 1), daddr (input, word_t) and dstore (input, word_t): the MEM-stage data request, address and write data.
REQ-007 The block SHALL have ports halt (input, 1): the MEM-stage halt indication.
REQ-008 The block SHALL have ports ramstate (input, ramstate_t) and ramload (input, word_t): the RAM status and read data.
REQ-009 The block SHALL have ports ramREN (output, 1), ramWEN (output, 1), ramaddr (output, word_t) and ramstore (output, word_t): the shared RAM port.
REQ-010 The block SHALL have ports ihit (output, 1), dhit (output, 1), iload (output, word_t) and dload (output, word_t): completion pulses and returned data.
REQ-011 The block SHALL have ports halted (output, 1) and timeout_err (output, 1): sticky status flags.

Function
REQ-012 The FSM SHALL have the states IDLE, IGRANT, DGRANT and HALTED.
REQ-013 In IDLE, a pending data request (dREN|dWEN) SHALL be granted first and move to DGRANT.
REQ-014 Exception to REQ-013: if the data-streak count equals DSTREAK_MAX and iREN is high, iREN SHALL win and move to IGRANT.
REQ-015 In IDLE with only iREN high, the FSM SHALL move to IGRANT; with no request it SHALL stay in IDLE.
REQ-016 The data-streak count SHALL increment on each completed data grant while iREN is high, saturate at DSTREAK_MAX, and clear on each completed instruction grant.
REQ-017 In IGRANT, ramREN=1, ramWEN=0 and ramaddr=iaddr.
REQ-018 In DGRANT, ramaddr=daddr and ramstore=dstore.
REQ-019 In DGRANT with dWEN=1, ramWEN=1 and ramREN=0; with dREN=1 only, ramREN=1. A write SHALL take precedence when dREN and dWEN are both high.
REQ-020 In IDLE and HALTED, ramREN=ramWEN=0, with ramaddr=0 and ramstore=0.
REQ-021 ihit SHALL be asserted combinationally for exactly the cycle in which the state is IGRANT and ramstate==ACCESS; iload=ramload in that cycle.
REQ-022 dhit SHALL follow the same rule as REQ-021 in DGRANT; dload=ramload in that cycle.
REQ-023 iload and dload SHALL be 0 outside their hit cycle.
REQ-024 After a hit, the next state SHALL be IDLE, giving a one-cycle bubble that makes arbitration non-sticky.
REQ-025 Requesters SHALL hold the request and address until hit; the arbiter SHALL NOT register addresses.
REQ-026 If the granted request deasserts before ACCESS (pipeline flush), the grant SHALL be aborted: next state IDLE, no hit, streak count unchanged.
REQ-027 A wait counter SHALL reset to 0 on entry to a grant state and increment each grant cycle without ACCESS.
REQ-028 When the wait counter reaches TIMEOUT, the block SHALL set timeout_err (sticky), abort the grant to IDLE and assert no hit.
REQ-029 ramstate ERROR SHALL be treated as not-ACCESS.
REQ-030 When halt=1 in IDLE, the next state SHALL be HALTED; when halt rises during a grant, that grant SHALL complete first.
REQ-031 HALTED SHALL be absorbing until reset, with halted=1, no grants and no hits.

Reset
REQ-032 Asserting nRST low SHALL immediately force IDLE, streak=0, wait counter=0, halted=0 and timeout_err=0; all outputs then take their IDLE values.
REQ-033 Reset mid-grant SHALL abandon the access with no hit pulse.

Structure
REQ-034 The ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t types SHALL come from cpu_types_pkg.
REQ-035 An arbiter state enum arb_state_t SHALL be added to cpu_types_pkg.
REQ-036 The design SHALL be a single module with no sub-module; wait and streak counters are inline registers, and output logic is combinational from state.

Verification
REQ-037 Scenario 1: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 for 3 cycles; ihit for 1 cycle with iload=0xDEADBEEF; IDLE next.
REQ-038 Scenario 2: iREN and dWEN together, daddr=0x80, dstore=0x1234 -> DGRANT first with ramWEN=1 and ramstore=0x1234; dhit; then IGRANT.
REQ-039 Scenario 3: iREN held while dREN is re-requested continuously -> exactly 2 data grants, then 1 instruction grant; the pattern repeats.
REQ-040 Scenario 4: DGRANT in BUSY, dREN dropped on cycle 2 -> IDLE next cycle, no dhit; with TIMEOUT=4 and ramstate never ACCESS -> timeout_err=1 after 4 wait cycles.
REQ-041 Scenario 5: halt=1 during a DGRANT -> dhit completes, then HALTED with halted=1; a later iREN gets no ramREN; nRST low clears halted asynchronously.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM handshake status and the
// memory arbiter's state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    HALTED = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and MEM-stage requesters onto one RAM port.
// Data wins by default; a bounded data streak lets a waiting fetch through.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  logic      halt,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     iload,
  output word_t     dload,
  output logic      halted,
  output logic      timeout_err
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = (DSTREAK_MAX > 1) ? $clog2(DSTREAK_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(TIMEOUT);
  localparam logic [SW-1:0] STREAK_FULL = SW'(DSTREAK_MAX);

  arb_state_t    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          timeout_err_q, timeout_err_d;

  logic          access;
  logic          d_req;
  logic [WW-1:0] wait_inc;

  assign access   = (ramstate == ACCESS);
  assign d_req    = dREN | dWEN;
  assign wait_inc = wait_q + WW'(1);

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    streak_d      = streak_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (halt)                                          state_d = HALTED;
        else if (d_req && !(streak_q == STREAK_FULL && iREN)) state_d = DGRANT;
        else if (iREN)                                     state_d = IGRANT;
      end
      IGRANT: begin
        if (access) begin
          state_d  = IDLE;
          streak_d = '0;
        end else if (!iREN) begin
          state_d = IDLE;
        end else if (wait_inc == WAIT_LIMIT) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      DGRANT: begin
        if (access) begin
          state_d = IDLE;
          if (iREN && streak_q != STREAK_FULL) streak_d = streak_q + SW'(1);
        end else if (!d_req) begin
          state_d = IDLE;
        end else if (wait_inc == WAIT_LIMIT) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      streak_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      streak_q      <= streak_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // RAM port and completion signals depend only on the current grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;

    case (state_q)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        ihit    = access;
        if (access) iload = ramload;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dhit     = access;
        if (access) dload = ramload;
      end
      default: ;
    endcase
  end

  assign halted      = (state_q == HALTED);
  assign timeout_err = timeout_err_q;

endmodule
